// File: rtl/vit_acs_ctrl_pkg.sv
// Shared definitions for the Viterbi ACS frame controller: state encoding,
// state count and path-metric initial-value constants.
package vit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_ACS  = 3'd2,
        ST_TB   = 3'd3,
        ST_DONE = 3'd4
    } vit_ctrl_state_e;

    localparam int unsigned NUM_STATES = 4;

    // Bit n set means PM_n starts at all ones; PM_0 starts at zero.
    localparam logic [3:0] PM_INIT_ONES_MASK = 4'b1110;
    localparam logic [3:0] PM_MSB_ALL_SET    = 4'b1111;

    function automatic logic [15:0] pm_init_value(input int unsigned idx);
        return PM_INIT_ONES_MASK[idx[1:0]] ? '1 : '0;
    endfunction

endpackage

// File: rtl/vit_acs_ctrl_if.sv
// Handshake and strobe bundle between the ACS frame controller and its
// symbol source / PMU / survivor memory.
interface vit_acs_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              i_start;
    logic [ADDR_W:0]   i_frame_len;
    logic              i_sym_valid;
    logic              o_sym_ready;
    logic [3:0]        i_pm_msb;
    logic              o_pm_init;
    logic              o_acs_en;
    logic              o_pm_norm;
    logic              o_sm_wr_en;
    logic [ADDR_W-1:0] o_sm_wr_addr;
    logic              o_tb_en;
    logic [ADDR_W-1:0] o_tb_addr;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_frame_len, i_sym_valid, i_pm_msb,
        output o_sym_ready, o_pm_init, o_acs_en, o_pm_norm, o_sm_wr_en,
               o_sm_wr_addr, o_tb_en, o_tb_addr, o_busy, o_done
    );

    modport slave (
        output i_start, i_frame_len, i_sym_valid, i_pm_msb,
        input  o_sym_ready, o_pm_init, o_acs_en, o_pm_norm, o_sm_wr_en,
               o_sm_wr_addr, o_tb_en, o_tb_addr, o_busy, o_done
    );
endinterface

// File: rtl/vit_acs_ctrl_step_counter.sv
// Loadable up/down step counter (ADDR_W+1 bits) with terminal-count flag;
// used for both the survivor write address and the traceback address.
module vit_step_counter #(
    parameter int unsigned ADDR_W   = 6,
    parameter bit          COUNT_UP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W:0]   load_val_i,
    input  logic              en_i,
    input  logic [ADDR_W:0]   term_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = COUNT_UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cnt_q[ADDR_W-1:0];
    assign tc_o   = (cnt_q == term_i);
endmodule

// File: rtl/vit_acs_ctrl.sv
// Frame sequencer for the Viterbi ACS/PMU/survivor memory: PM init, one
// trellis step per accepted symbol with normalisation, then traceback sweep.
module vit_acs_ctrl
    import vit_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned PM_W   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vit_acs_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_INIT = ST_INIT;
    localparam logic [2:0] S_ACS  = ST_ACS;
    localparam logic [2:0] S_TB   = ST_TB;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    if (PM_W < 1) begin : g_bad_pm_w
        $error("vit_acs_ctrl: PM_W must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   len_m1;
    logic              len_ok;
    logic              accept;
    logic              last_accept;
    logic              wr_tc, tb_tc;
    logic [ADDR_W-1:0] wr_addr, tb_addr;

    assign len_ok      = (bus.i_frame_len != '0) && (bus.i_frame_len <= MAX_LEN);
    assign len_m1      = len_q - 1'b1;
    assign accept      = (state_q == S_ACS) && bus.i_sym_valid;
    assign last_accept = accept && wr_tc;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start && len_ok) begin
                    len_d   = bus.i_frame_len;
                    state_d = S_INIT;
                end
            end
            S_INIT: state_d = S_ACS;
            S_ACS:  if (last_accept) state_d = S_TB;
            S_TB:   if (tb_tc) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    vit_step_counter #(
        .ADDR_W   (ADDR_W),
        .COUNT_UP (1'b1)
    ) u_wr_cnt (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (state_q == S_INIT),
        .load_val_i ('0),
        .en_i       (accept),
        .term_i     (len_m1),
        .addr_o     (wr_addr),
        .tc_o       (wr_tc)
    );

    // Traceback starts at len-1, loaded on the final accept so TB needs no setup cycle.
    vit_step_counter #(
        .ADDR_W   (ADDR_W),
        .COUNT_UP (1'b0)
    ) u_tb_cnt (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (last_accept),
        .load_val_i (len_m1),
        .en_i       ((state_q == S_TB) && !tb_tc),
        .term_i     ('0),
        .addr_o     (tb_addr),
        .tc_o       (tb_tc)
    );

    assign bus.o_sym_ready  = (state_q == S_ACS);
    assign bus.o_pm_init    = (state_q == S_INIT);
    assign bus.o_acs_en     = accept;
    assign bus.o_pm_norm    = accept && (bus.i_pm_msb == PM_MSB_ALL_SET);
    assign bus.o_sm_wr_en   = accept;
    assign bus.o_sm_wr_addr = accept ? wr_addr : '0;
    assign bus.o_tb_en      = (state_q == S_TB);
    assign bus.o_tb_addr    = (state_q == S_TB) ? tb_addr : '0;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_done       = (state_q == S_DONE);
endmodule

// File: tb/tb_vit_acs_ctrl.sv
// Directed bench for vit_acs_ctrl with address/done scoreboard queues.
module tb_vit_acs_ctrl;
    localparam int unsigned ADDR_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [ADDR_W-1:0] wr_q[$];
    logic [ADDR_W-1:0] tb_q[$];
    bit                done_q[$];

    vit_acs_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    vit_acs_ctrl #(
        .ADDR_W (ADDR_W),
        .PM_W   (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.o_busy, bus.o_pm_init, bus.o_acs_en, bus.o_sm_wr_en,
                bus.o_tb_en, bus.o_done, bus.o_sym_ready, bus.o_pm_norm};
    endfunction

    // Scoreboard monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_sm_wr_en) begin
                check("wr_expected", 32'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) check("wr_addr", 32'(bus.o_sm_wr_addr), 32'(wr_q.pop_front()));
            end
            if (bus.o_tb_en) begin
                check("tb_expected", 32'(tb_q.size() > 0), 1);
                if (tb_q.size() > 0) check("tb_addr", 32'(bus.o_tb_addr), 32'(tb_q.pop_front()));
            end
            if (bus.o_done) begin
                check("done_expected", 32'(done_q.size() > 0), 1);
                if (done_q.size() > 0) void'(done_q.pop_front());
            end
            if (bus.o_acs_en)
                check("pm_norm", 32'(bus.o_pm_norm), 32'(bus.i_pm_msb == 4'b1111));
            else
                check("norm_idle", 32'(bus.o_pm_norm), 0);
        end
    end

    task automatic frame(input int len, input bit toggle, input int msb_mode, input bit start_in_tb);
        int cyc = 0;
        int acc = 0;
        bit seen = 1'b0;
        bit poked = 1'b0;
        bit poke_pending = 1'b0;
        for (int i = 0; i < len; i++) wr_q.push_back(6'(i));
        for (int i = len - 1; i >= 0; i--) tb_q.push_back(6'(i));
        done_q.push_back(1'b1);
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_frame_len = 7'(len); bus.i_sym_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        while (!seen && cyc < 4 * len + 20) begin
            bus.i_start     = poke_pending;
            poke_pending    = 1'b0;
            bus.i_sym_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            case (msb_mode)
                1:       bus.i_pm_msb = (acc == 0) ? 4'b1111 : 4'b1110;
                2:       bus.i_pm_msb = 4'b1111;
                default: bus.i_pm_msb = 4'b0000;
            endcase
            @(negedge clk);
            if (bus.o_sym_ready && !bus.i_sym_valid)
                check("stall_strobes", 32'({bus.o_acs_en, bus.o_sm_wr_en, bus.o_pm_norm}), 0);
            if (bus.o_acs_en) acc++;
            if (start_in_tb && bus.o_tb_en && !poked) begin
                poke_pending = 1'b1;
                poked = 1'b1;
            end
            seen = bus.o_done;
            @(posedge clk); #1;
            cyc++;
        end
        bus.i_start = 1'b0; bus.i_sym_valid = 1'b0; bus.i_pm_msb = 4'b0000;
        check("done_seen", 32'(seen), 1);
        check("acs_pulses", 32'(acc), 32'(len));
        @(negedge clk);
        check("busy_after_done", 32'(bus.o_busy), 0);
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("tb_q_drained", 32'(tb_q.size()), 0);
        check("done_q_drained", 32'(done_q.size()), 0);
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_frame_len = '0; bus.i_sym_valid = 1'b0; bus.i_pm_msb = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs()), 0);
        check("reset_addrs", 32'({bus.o_sm_wr_addr, bus.o_tb_addr}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // len=4, valid held high: cycle-exact timeline, start+valid together in IDLE
        for (int i = 0; i < 4; i++) wr_q.push_back(6'(i));
        for (int i = 3; i >= 0; i--) tb_q.push_back(6'(i));
        done_q.push_back(1'b1);
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_frame_len = 7'd4; bus.i_sym_valid = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            logic [7:0] exp;
            @(negedge clk);
            exp = {(c >= 1 && c <= 10), (c == 1), (c >= 2 && c <= 5), (c >= 2 && c <= 5),
                   (c >= 6 && c <= 9), (c == 10), (c >= 2 && c <= 5), 1'b0};
            check($sformatf("len4_cycle%0d", c), 32'(outs()), 32'(exp));
            @(posedge clk); #1;
            bus.i_start = 1'b0;
        end
        bus.i_sym_valid = 1'b0;
        check("len4_queues", 32'(wr_q.size() + tb_q.size() + done_q.size()), 0);

        // Toggling valid, len=5
        frame(5, 1'b1, 0, 1'b0);
        // Normalisation on first step only
        frame(2, 1'b0, 1, 1'b0);
        // msb all set on stall cycles must not normalise
        frame(3, 1'b1, 2, 1'b0);
        // Start pulse during traceback is ignored
        frame(4, 1'b0, 0, 1'b1);
        // Maximum length
        frame(64, 1'b0, 0, 1'b0);

        // Illegal lengths are ignored
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_frame_len = 7'd0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("len0_idle", 32'({bus.o_busy, bus.o_pm_init}), 0);
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_frame_len = 7'd65;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("len65_idle", 32'({bus.o_busy, bus.o_pm_init}), 0);

        // Reset mid-ACS after 3 accepts, len=8
        for (int i = 0; i < 3; i++) wr_q.push_back(6'(i));
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_frame_len = 7'd8;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        bus.i_sym_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.o_busy), 1);
        @(posedge clk); #1;
        bus.i_sym_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outs", 32'(outs()), 0);
        check("three_accepts", 32'(wr_q.size()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tb_q.delete(); done_q.delete();
        bus.i_sym_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.i_sym_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(outs()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
